threshold_ram_writer: RTL

THRESHOLD_RAM_WRITER -- requirements
Module: threshold_ram_writer

---
 rtl/threshold_pkg.sv | 18 +
 rtl/threshold_ram_writer_if.sv | 25 ++
 rtl/block_mean.sv | 40 ++++
 rtl/threshold_ram_writer.sv | 108 ++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// Shared frame geometry and FSM encoding for the threshold RAM writer.
package threshold_pkg;
  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int ADDR_W  = 7;
  localparam int BLOCK_W = 8;
  localparam int PIX_W   = 8;
  localparam int SUM_W   = 11;
  localparam int K_W     = $clog2(BLOCK_W);
  localparam int BLK_W   = ADDR_W - K_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/threshold_ram_writer_if.sv
// Pixel stream in, threshold RAM write port and status out.
interface threshold_ram_writer_if;
  import threshold_pkg::*;

  logic              iStart;
  logic              iValid;
  logic [PIX_W-1:0]  iPixel;
  logic              oReady;
  logic              oWe;
  logic [ADDR_W-1:0] oCol;
  logic [ADDR_W-1:0] oRow;
  logic [PIX_W-1:0]  oData;
  logic              oBusy;
  logic              oDone;

  modport master (
    output iStart, iValid, iPixel,
    input  oReady, oWe, oCol, oRow, oData, oBusy, oDone
  );

  modport slave (
    input  iStart, iValid, iPixel,
    output oReady, oWe, oCol, oRow, oData, oBusy, oDone
  );
endinterface

// File: rtl/block_mean.sv
// Accumulates one 8-pixel block and latches (mean - OFFSET), floored at zero.
module block_mean
  import threshold_pkg::*;
#(
  parameter int OFFSET = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic             last,
  input  logic [PIX_W-1:0] pixel,
  output logic [PIX_W-1:0] thresh
);
  localparam logic [PIX_W-1:0] OFF = PIX_W'(OFFSET);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_nxt;
  logic [PIX_W-1:0] mean;

  // The 8th pixel is folded in on the same edge that latches the threshold.
  assign sum_nxt = sum + SUM_W'(pixel);
  assign mean    = sum_nxt[SUM_W-1:K_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum    <= '0;
      thresh <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (acc_en) begin
      if (last) begin
        sum    <= '0;
        thresh <= (mean > OFF) ? mean - OFF : '0;
      end else begin
        sum <= sum_nxt;
      end
    end
  end
endmodule

// File: rtl/threshold_ram_writer.sv
// Per-block threshold writer: 8 pixels in, 8 identical threshold writes out.
// state    | meaning
// ST_IDLE  | waiting for iStart, outputs quiet
// ST_ACCUM | accepting pixels of the current block
// ST_WRITE | 8 writes of the latched threshold across the block's columns
// ST_DONE  | one-cycle frame completion pulse
module threshold_ram_writer
  import threshold_pkg::*;
#(
  parameter int OFFSET = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  threshold_ram_writer_if.slave bus
);
  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] row;
  logic [BLK_W-1:0]  blk;
  logic [K_W-1:0]    pix_left;
  logic [K_W-1:0]    wr_left;
  logic [PIX_W-1:0]  thresh;

  logic ready, we, busy, done;
  logic start, accept, last_pix, last_wr, last_blk, last_row;

  assign start    = (state == ST_IDLE) && bus.iStart;
  assign accept   = ready && bus.iValid;
  assign last_pix = (pix_left == '0);
  assign last_wr  = (wr_left == '0);
  assign last_blk = (blk == BLK_W'(IMG_W / BLOCK_W - 1));
  assign last_row = (row == ADDR_W'(IMG_H - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    we        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.iStart) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        ready = 1'b1;
        if (bus.iValid && last_pix) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        we = 1'b1;
        if (last_wr) state_nxt = (last_row && last_blk) ? ST_DONE : ST_ACCUM;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Down-counters wrap from 0 back to 7, so they reload themselves per block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row      <= '0;
      blk      <= '0;
      pix_left <= '0;
      wr_left  <= '0;
    end else if (start) begin
      row      <= '0;
      blk      <= '0;
      pix_left <= K_W'(BLOCK_W - 1);
      wr_left  <= K_W'(BLOCK_W - 1);
    end else begin
      if (accept) pix_left <= pix_left - K_W'(1);
      if (we) begin
        wr_left <= wr_left - K_W'(1);
        if (last_wr) begin
          blk <= blk + BLK_W'(1);
          if (last_blk) row <= row + ADDR_W'(1);
        end
      end
    end
  end

  block_mean #(.OFFSET(OFFSET)) u_mean (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start),
    .acc_en  (accept),
    .last    (last_pix),
    .pixel   (bus.iPixel),
    .thresh  (thresh)
  );

  assign bus.oReady = ready;
  assign bus.oWe    = we;
  assign bus.oBusy  = busy;
  assign bus.oDone  = done;
  assign bus.oRow   = we ? row : '0;
  assign bus.oCol   = we ? {blk, ~wr_left} : '0;
  assign bus.oData  = we ? thresh : '0;
endmodule
